core_supervisor: RTL

Host-side supervisor for the matrix-multiply control unit. It drives the control unit's 2-bit `status` launch input, watches `end_process`, and measures run length. It enforces a watchdog timeout and returns the core to a clean state by pulsing `core_rst` before every new run. It sits between the host/register interface and the control unit.

---
 rtl/core_supervisor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/core_supervisor.sv
// core_supervisor: host-side launch/watchdog/reset sequencer for the matrix-multiply control unit.
// Drives the control unit's 2-bit status launch code, measures run length, enforces a
// watchdog limit and pulses core_rst ahead of every run so each launch starts clean.
module core_supervisor #(
    parameter logic [23:0] TIMEOUT    = 24'd1_000_000,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_start,
    input  logic        host_abort,
    input  logic        host_ack,
    input  logic        end_process,
    output logic [1:0]  status,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        abort_err,
    output logic [23:0] cycle_count
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RST_W-1:0] RST_LOAD     = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - 24'd1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    typedef enum logic [2:0] {
        S_CRST  = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             state_q;
    logic [RST_W-1:0]   rst_cnt_q;
    logic [RST_W-1:0]   rst_cnt_d;
    logic [CNT_W-1:0]   cycle_count_q;
    logic [CNT_W-1:0]   cycle_count_d;
    logic [1:0]         status_q;
    logic               core_rst_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_err_q;
    logic               abort_err_q;
    logic               timeout_hit;
    logic               rst_cnt_zero;

    // Datapath helpers: saturating run counter, reset-pulse countdown, watchdog compare.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (cycle_count_q != CNT_MAX) begin
            cycle_count_d = cycle_count_q + 24'd1;
        end
        rst_cnt_zero = (rst_cnt_q == '0);
        rst_cnt_d    = rst_cnt_q;
        if (!rst_cnt_zero) begin
            rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
        timeout_hit = (cycle_count_q == TIMEOUT_LAST);
    end

    // Supervisor FSM; every output is a register updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_CRST;
            rst_cnt_q     <= RST_LOAD;
            cycle_count_q <= '0;
            status_q      <= ST_IDLE;
            core_rst_q    <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            abort_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_CRST: begin
                    if (rst_cnt_zero) begin
                        state_q    <= S_IDLE;
                        core_rst_q <= 1'b0;
                    end else begin
                        rst_cnt_q  <= rst_cnt_d;
                    end
                end

                S_IDLE: begin
                    // A launch while end_process is still high means the core is stale.
                    if (host_start && !end_process) begin
                        state_q       <= S_RUN;
                        status_q      <= ST_RUN;
                        busy_q        <= 1'b1;
                        cycle_count_q <= '0;
                        timeout_err_q <= 1'b0;
                        abort_err_q   <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (end_process) begin
                        state_q  <= S_DONE;
                        status_q <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (host_abort) begin
                        state_q     <= S_FAULT;
                        status_q    <= ST_FAULT;
                        busy_q      <= 1'b0;
                        abort_err_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q       <= S_FAULT;
                        status_q      <= ST_FAULT;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cycle_count_q <= cycle_count_d;
                    end
                end

                S_DONE: begin
                    if (host_ack) begin
                        state_q    <= S_CRST;
                        rst_cnt_q  <= RST_LOAD;
                        status_q   <= ST_IDLE;
                        core_rst_q <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end

                S_FAULT: begin
                    // Error flags survive the ack so the host can still read the cause.
                    if (host_ack) begin
                        state_q    <= S_CRST;
                        rst_cnt_q  <= RST_LOAD;
                        status_q   <= ST_IDLE;
                        core_rst_q <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= S_CRST;
                    rst_cnt_q  <= RST_LOAD;
                    status_q   <= ST_IDLE;
                    core_rst_q <= 1'b1;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign status      = status_q;
    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign abort_err   = abort_err_q;
    assign cycle_count = cycle_count_q;

endmodule
